// File: rtl/embedded_bht_pkg.sv
// Shared core package: user configuration and branch-prediction types.
// The BHT update/prediction structs sit beside the other branch-predict types.
package embedded_bht_pkg;

    typedef struct packed {
        int unsigned BHTEntries;
        int unsigned VLEN;
        bit          RVC;
    } user_cfg_t;

    localparam user_cfg_t UserCfgDefault = '{BHTEntries: 32, VLEN: 32, RVC: 1'b1};

    typedef enum logic [1:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JUMP,
        CF_RETURN
    } cf_t;

    typedef struct packed {
        logic        valid;
        cf_t         cf;
        logic [63:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    localparam logic [1:0] CNT_WEAK_TAKEN     = 2'b10;
    localparam logic [1:0] CNT_WEAK_NOT_TAKEN = 2'b01;

    // Two-bit saturating counter step.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/embedded_bht.sv
// Untagged branch history table: flop array of valid bit + 2-bit counter,
// one-cycle registered lookup with write-first bypass from the update port.
module embedded_bht
    import embedded_bht_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = UserCfgDefault.BHTEntries,
    parameter int unsigned VLEN       = UserCfgDefault.VLEN,
    parameter bit          RVC        = UserCfgDefault.RVC
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    input  logic            upd_valid_i,
    input  logic [VLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o
);

    localparam int unsigned IW  = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam int unsigned OFF = RVC ? 1 : 2;

    logic [NR_ENTRIES-1:0] r_valid;
    logic [1:0]            r_cnt [NR_ENTRIES];
    bht_prediction_t       r_pred;

    bht_update_t w_upd;
    logic [63:0] w_lkp_pc;
    logic [IW-1:0] w_upd_idx;
    logic [IW-1:0] w_lkp_idx;
    logic          w_upd_en;
    logic [1:0]    w_new_cnt;
    logic          w_bypass;
    logic          w_hit_valid;
    logic [1:0]    w_hit_cnt;
    logic          w_lkp_en;
    logic          w_unused;

    assign w_upd    = '{valid: upd_valid_i, pc: 64'(upd_pc_i), taken: upd_taken_i};
    assign w_lkp_pc = 64'(lookup_pc_i);

    // Upper PC bits are deliberately ignored: entries alias by low index bits.
    assign w_upd_idx = w_upd.pc[OFF+IW-1:OFF];
    assign w_lkp_idx = w_lkp_pc[OFF+IW-1:OFF];
    assign w_unused  = ^{w_upd.pc, w_lkp_pc};

    assign w_upd_en  = w_upd.valid & ~debug_mode_i & ~flush_i;
    assign w_new_cnt = r_valid[w_upd_idx] ? sat_step(r_cnt[w_upd_idx], w_upd.taken)
                     : (w_upd.taken ? CNT_WEAK_TAKEN : CNT_WEAK_NOT_TAKEN);

    assign w_bypass    = w_upd_en && (w_upd_idx == w_lkp_idx);
    assign w_hit_valid = w_bypass | r_valid[w_lkp_idx];
    assign w_hit_cnt   = w_bypass ? w_new_cnt : r_cnt[w_lkp_idx];
    assign w_lkp_en    = lookup_valid_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                r_cnt[i] <= 2'b00;
            end
            r_pred <= '0;
        end else begin
            // Flush drops any same-cycle update; counters keep their values.
            if (flush_i) begin
                r_valid <= '0;
            end else if (w_upd_en) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_cnt[w_upd_idx]   <= w_new_cnt;
            end
            r_pred.valid <= w_lkp_en & w_hit_valid;
            r_pred.taken <= w_lkp_en & w_hit_valid & w_hit_cnt[1];
        end
    end

    assign pred_valid_o = r_pred.valid;
    assign pred_taken_o = r_pred.taken;

endmodule

// File: tb/tb_embedded_bht.sv
// Directed bench for embedded_bht (32 entries, RVC index = pc[5:1]).
module tb_embedded_bht;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        debug_mode_i;
    logic        lookup_valid_i;
    logic [31:0] lookup_pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        pred_valid_o;
    logic        pred_taken_o;

    int vectors;
    int miscompares;

    embedded_bht #(
        .NR_ENTRIES(32),
        .VLEN      (32),
        .RVC       (1'b1)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .debug_mode_i  (debug_mode_i),
        .lookup_valid_i(lookup_valid_i),
        .lookup_pc_i   (lookup_pc_i),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .pred_valid_o  (pred_valid_o),
        .pred_taken_o  (pred_taken_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic rs, input logic fl, input logic dbg,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic lv, input logic [31:0] lpc);
        rst_i          = rs;
        flush_i        = fl;
        debug_mode_i   = dbg;
        upd_valid_i    = uv;
        upd_pc_i       = upc;
        upd_taken_i    = ut;
        lookup_valid_i = lv;
        lookup_pc_i    = lpc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, pc, taken, 1'b0, 32'h0);
    endtask

    task automatic lkp(input logic [31:0] pc);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, pc);
    endtask

    task automatic check(input string tag, input logic ev, input logic et);
        vectors++;
        assert (pred_valid_o === ev) else begin
            miscompares++;
            $error("FAIL %s pred_valid_o observed=%b expected=%b", tag, pred_valid_o, ev);
        end
        vectors++;
        assert (pred_taken_o === et) else begin
            miscompares++;
            $error("FAIL %s pred_taken_o observed=%b expected=%b", tag, pred_taken_o, et);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset overrides a same-cycle update and lookup.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0010);
        check("reset", 1'b0, 1'b0);

        lkp(32'h8000_0000);
        check("cold_lookup", 1'b0, 1'b0);

        // Index 8: invalid->10, 11, 11 saturating.
        upd(32'h8000_0010, 1'b1);
        lkp(32'h8000_0010);
        check("first_taken_10", 1'b1, 1'b1);
        upd(32'h8000_0010, 1'b1);
        upd(32'h8000_0010, 1'b1);
        lkp(32'h8000_0010);
        check("sat_11", 1'b1, 1'b1);
        upd(32'h8000_0010, 1'b0);
        lkp(32'h8000_0010);
        check("dec_10", 1'b1, 1'b1);
        upd(32'h8000_0010, 1'b0);
        lkp(32'h8000_0010);
        check("dec_01", 1'b1, 1'b0);
        upd(32'h8000_0010, 1'b0);
        upd(32'h8000_0010, 1'b0);
        lkp(32'h8000_0010);
        check("sat_00", 1'b1, 1'b0);
        upd(32'h8000_0010, 1'b1);
        lkp(32'h8000_0010);
        check("inc_from_00_to_01", 1'b1, 1'b0);

        // Write-first bypass on an invalid entry (index 2).
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0104);
        check("bypass_new_entry", 1'b1, 1'b1);
        // Bypass on a valid entry: 10 -> 01 visible immediately.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 1'b1, 32'h0000_0104);
        check("bypass_valid_dec", 1'b1, 1'b0);
        // Update on another index must not bypass into this lookup.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 1'b1, 32'h0000_0006);
        check("no_bypass_other_idx", 1'b0, 1'b0);

        // Aliasing at index 2 (entry now 10).
        upd(32'h8000_0004, 1'b0);
        lkp(32'h8000_0044);
        check("alias_a_to_b", 1'b1, 1'b0);
        upd(32'h8000_0044, 1'b1);
        lkp(32'h8000_0004);
        check("alias_b_to_a", 1'b1, 1'b1);

        // Index 5: train to 11, then flush with update and lookup same cycle.
        upd(32'h0000_000A, 1'b1);
        upd(32'h0000_000A, 1'b1);
        lkp(32'h0000_000A);
        check("idx5_trained", 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_000A, 1'b1, 1'b1, 32'h0000_000A);
        check("flush_cycle_lookup", 1'b0, 1'b0);
        lkp(32'h0000_000A);
        check("after_flush", 1'b0, 1'b0);
        lkp(32'h8000_0010);
        check("flush_clears_all", 1'b0, 1'b0);
        upd(32'h0000_000A, 1'b0);
        lkp(32'h0000_000A);
        check("reinit_01", 1'b1, 1'b0);
        upd(32'h0000_000A, 1'b1);
        lkp(32'h0000_000A);
        check("reinit_01_inc_10", 1'b1, 1'b1);

        // Debug-mode update ignored (index 9).
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0012, 1'b1, 1'b0, 32'h0);
        lkp(32'h0000_0012);
        check("debug_upd_ignored", 1'b0, 1'b0);

        // No lookup on a valid taken entry gives zeros.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_000A);
        check("lookup_valid_low", 1'b0, 1'b0);

        // Reset mid-operation discards the lookup and clears the table.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_000A);
        check("reset_mid_op", 1'b0, 1'b0);
        lkp(32'h0000_000A);
        check("after_reset_invalid", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
